m6502_sequencer: RTL and testbench
==================================

# m6502_sequencer

Parametrised instruction sequencer for the M6502 core. It owns the one-hot timing ring and the instruction register, and decodes a fixed opcode subset into the datapath enable vector. It replaces the combinational-only decode, which relied on an external timing source. It sits between the memory data bus and the register/PC/address datapath. It adds the `ready` stall (6502 RDY semantics), multi-byte absolute addressing, and optional illegal-opcode trapping.

## Interface
- `TIMING_WIDTH`, default 8: number of one-hot T-states (T0..T(N-1)); minimum 4.
- `ENABLE_WIDTH`, default 64: width of the enable vector. Bit indices come from the shared enable-define header; undefined bits are driven 0.

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `ready`  in  1  memory ready; low stalls read cycles.
- `data_in`  in  8  memory read data; sampled as the opcode in T0.
- `timing`  out  TIMING_WIDTH  one-hot current T-state.
- `opcode`  out  8  instruction register.
- `sync`  out  1  high while in T0 (opcode fetch).
- `enables`  out  ENABLE_WIDTH  datapath control, combinational from state, opcode, ready and reset.
- `illegal`  out  1  sticky illegal-opcode flag.

## Operation
- **Reset values** (registered on the cycle `reset` is high):
  - `timing`=1 (T0).
  - `opcode`=8'hEA.
  - `illegal`=0.
  - While `reset` is high, `enables` has only TIMING_RESET set.
- **Enables by T-state and opcode.** TIMING_RESET returns the ring to T0 on the next edge.
  - T0, any opcode: IR_LOAD, PC_INC. `opcode` <= `data_in` on the edge if `ready`.
  - NOP EA: T1: TIMING_RESET.
  - LDA# A9 / LDX# A2 / LDY# A0: T1: PC_INC, RA/RX/RY_DATA_IN_Q respectively, TIMING_RESET.
  - JMP abs 4C:
    - T1: PC_INC, ADL_LOAD.
    - T2: ADH_LOAD, PC_LOAD, TIMING_RESET.
  - LDA abs AD:
    - T1: PC_INC, ADL_LOAD.
    - T2: PC_INC, ADH_LOAD.
    - T3: ADDR_SEL_AD, RA_DATA_IN_Q, TIMING_RESET.
  - STA abs 8D: as LDA abs, but T3 is ADDR_SEL_AD, WRITE_EN, TIMING_RESET.
- **Ring advance.** Without TIMING_RESET, the ring shifts one position per enabled cycle.
  - If it reaches T(N-1) without a TIMING_RESET, it is forced to T0. This is a safety net; it is unreachable for the decoded set.
- **Stall.** When `ready`=0 in a read cycle (any cycle without WRITE_EN):
  - all `enables` are 0;
  - `timing` and `opcode` hold.
- **Write cycles.** These (STA T3) ignore `ready` and always complete.
- **Illegal opcode.** Any opcode outside the set above is illegal. Behaviour is set by Configuration.
- **Simultaneous events.** `reset` dominates `ready`, `data_in` and trap state.

## Timing
- Instruction cycle counts, T0 included: NOP 2, immediates 2, JMP abs 3, LDA/STA abs 4.
- `sync` is high exactly one cycle per instruction, plus one extra cycle per stalled T0 cycle.
- `enables` is valid in the same cycle as the `timing` state it decodes. There is zero latency from `ready`.
- Back-to-back instructions have no bubble: the cycle after TIMING_RESET is T0.
- Reset mid-instruction aborts it. The next edge after `reset` deasserts starts from T0 with `opcode`=EA.

## Configuration
- `M6502_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in T1 sets `illegal`=1 on that edge.
  - From T1 onward, `enables`=0 and `timing` freezes at T1 until `reset`.
  - `sync` stays 0.
- Undefined:
  - An illegal opcode executes as NOP EA (T1: TIMING_RESET).
  - `illegal` is tied 0.

## Test plan
- Reset 3 cycles, release with `data_in`=EA, `ready`=1 -> `timing` sequence 01,02,01; `sync` 1,0,1; PC_INC only in T0.
- `data_in` A9 then 42 -> T1 asserts PC_INC+RA_DATA_IN_Q+TIMING_RESET; next cycle T0.
- Sequence 4C,00,80 -> 3 cycles; T2 asserts PC_LOAD+ADH_LOAD; `sync` returns on the 4th cycle.
- 8D,10,20 with `ready`=0 during T2 and T3 -> T2 holds with `enables`=0; T3 asserts WRITE_EN despite `ready`=0; total 5 cycles.
- Opcode 02:
  - with the macro -> `illegal`=1 from the T1 edge; `timing` stuck at 02 for 10 cycles; cleared by `reset`;
  - without the macro -> 2-cycle NOP, `illegal`=0.
- Assert `reset` in T2 of AD -> next cycle `timing`=01, `opcode`=EA, only TIMING_RESET set during reset.

Source files
------------

// File: rtl/m6502_sequencer.sv
// m6502_sequencer: one-hot T-state ring, instruction register and opcode decode into datapath enables.
// Zero latency: enables decode the current T-state; ready low stalls read cycles, write cycles always complete.
// Optional illegal-opcode trap when M6502_ILLEGAL_TRAP_EN is defined; otherwise illegal opcodes run as NOP.
module m6502_sequencer #(
  parameter int TIMING_WIDTH = 8,
  parameter int ENABLE_WIDTH = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ready,
  input  logic [7:0]              data_in,
  output logic [TIMING_WIDTH-1:0] timing,
  output logic [7:0]              opcode,
  output logic                    sync,
  output logic [ENABLE_WIDTH-1:0] enables,
  output logic                    illegal
);

  // Enable bit indices, shared with the datapath.
  localparam int EN_TIMING_RESET = 0;
  localparam int EN_IR_LOAD      = 1;
  localparam int EN_PC_INC       = 2;
  localparam int EN_PC_LOAD      = 3;
  localparam int EN_ADL_LOAD     = 4;
  localparam int EN_ADH_LOAD     = 5;
  localparam int EN_ADDR_SEL_AD  = 6;
  localparam int EN_RA_DATA_IN_Q = 7;
  localparam int EN_RX_DATA_IN_Q = 8;
  localparam int EN_RY_DATA_IN_Q = 9;
  localparam int EN_WRITE_EN     = 10;

  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;

  localparam logic [TIMING_WIDTH-1:0] T0 = TIMING_WIDTH'(1);

  typedef enum logic {ST_RUN, ST_TRAP} mode_t;

  mode_t                   mode_q, mode_d;
  logic [TIMING_WIDTH-1:0] timing_q, timing_d;
  logic [7:0]              opcode_q, opcode_d;
  logic [ENABLE_WIDTH-1:0] dec_en;
  logic                    go;
  logic                    trap_now;

  always_comb begin
    dec_en = '0;
    if (timing_q[0]) begin
      dec_en[EN_IR_LOAD] = 1'b1;
      dec_en[EN_PC_INC]  = 1'b1;
    end else if (timing_q[1]) begin
      case (opcode_q)
        OP_NOP: dec_en[EN_TIMING_RESET] = 1'b1;
        OP_LDA_IMM: begin
          dec_en[EN_PC_INC]       = 1'b1;
          dec_en[EN_RA_DATA_IN_Q] = 1'b1;
          dec_en[EN_TIMING_RESET] = 1'b1;
        end
        OP_LDX_IMM: begin
          dec_en[EN_PC_INC]       = 1'b1;
          dec_en[EN_RX_DATA_IN_Q] = 1'b1;
          dec_en[EN_TIMING_RESET] = 1'b1;
        end
        OP_LDY_IMM: begin
          dec_en[EN_PC_INC]       = 1'b1;
          dec_en[EN_RY_DATA_IN_Q] = 1'b1;
          dec_en[EN_TIMING_RESET] = 1'b1;
        end
        OP_JMP_ABS, OP_LDA_ABS, OP_STA_ABS: begin
          dec_en[EN_PC_INC]   = 1'b1;
          dec_en[EN_ADL_LOAD] = 1'b1;
        end
        default: begin
`ifndef M6502_ILLEGAL_TRAP_EN
          dec_en[EN_TIMING_RESET] = 1'b1;
`endif
        end
      endcase
    end else if (timing_q[2]) begin
      case (opcode_q)
        OP_JMP_ABS: begin
          dec_en[EN_ADH_LOAD]     = 1'b1;
          dec_en[EN_PC_LOAD]      = 1'b1;
          dec_en[EN_TIMING_RESET] = 1'b1;
        end
        OP_LDA_ABS, OP_STA_ABS: begin
          dec_en[EN_PC_INC]   = 1'b1;
          dec_en[EN_ADH_LOAD] = 1'b1;
        end
        default: ;
      endcase
    end else if (timing_q[3]) begin
      case (opcode_q)
        OP_LDA_ABS: begin
          dec_en[EN_ADDR_SEL_AD]  = 1'b1;
          dec_en[EN_RA_DATA_IN_Q] = 1'b1;
          dec_en[EN_TIMING_RESET] = 1'b1;
        end
        OP_STA_ABS: begin
          dec_en[EN_ADDR_SEL_AD]  = 1'b1;
          dec_en[EN_WRITE_EN]     = 1'b1;
          dec_en[EN_TIMING_RESET] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Write cycles cannot be stretched by the memory, so they ignore ready.
  assign go = ready | dec_en[EN_WRITE_EN];

`ifdef M6502_ILLEGAL_TRAP_EN
  logic op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (opcode_q)
      OP_NOP, OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM,
      OP_JMP_ABS, OP_LDA_ABS, OP_STA_ABS: op_legal = 1'b1;
      default: ;
    endcase
  end

  assign trap_now = (mode_q == ST_RUN) & timing_q[1] & ~op_legal;
  assign illegal  = (mode_q == ST_TRAP);
`else
  assign trap_now = 1'b0;
  assign illegal  = 1'b0;
`endif

  always_comb begin
    mode_d   = mode_q;
    timing_d = timing_q;
    opcode_d = opcode_q;
    if (mode_q == ST_RUN && go) begin
      if (timing_q[0]) opcode_d = data_in;
      if (trap_now)
        mode_d = ST_TRAP;
      else if (dec_en[EN_TIMING_RESET])
        timing_d = T0;
      else
        // Rotation wraps T(N-1) back to T0 as a safety net.
        timing_d = {timing_q[TIMING_WIDTH-2:0], timing_q[TIMING_WIDTH-1]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q   <= ST_RUN;
      timing_q <= T0;
      opcode_q <= OP_NOP;
    end else begin
      mode_q   <= mode_d;
      timing_q <= timing_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    enables = '0;
    if (reset)
      enables[EN_TIMING_RESET] = 1'b1;
    else if (mode_q == ST_RUN && go)
      enables = dec_en;
  end

  assign timing = timing_q;
  assign opcode = opcode_q;
  assign sync   = timing_q[0];

endmodule

// File: tb/tb_m6502_sequencer.sv
// Scoreboard bench for m6502_sequencer: each directed step queues the outputs expected for that cycle,
// a monitor on the falling edge pops and compares them.
module tb_m6502_sequencer;

  localparam int TW = 8;
  localparam int EW = 64;

  localparam logic [EW-1:0] TR  = 64'h001;
  localparam logic [EW-1:0] IRL = 64'h002;
  localparam logic [EW-1:0] PCI = 64'h004;
  localparam logic [EW-1:0] PCL = 64'h008;
  localparam logic [EW-1:0] ADL = 64'h010;
  localparam logic [EW-1:0] ADH = 64'h020;
  localparam logic [EW-1:0] ASA = 64'h040;
  localparam logic [EW-1:0] RA  = 64'h080;
  localparam logic [EW-1:0] RX  = 64'h100;
  localparam logic [EW-1:0] RY  = 64'h200;
  localparam logic [EW-1:0] WE  = 64'h400;
  localparam logic [EW-1:0] NONE = 64'h0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ready = 1'b1;
  logic [7:0]    data_in = 8'hEA;
  logic [TW-1:0] timing;
  logic [7:0]    opcode;
  logic          sync;
  logic [EW-1:0] enables;
  logic          illegal;

  typedef struct {
    int            id;
    logic [TW-1:0] t;
    logic [EW-1:0] en;
    logic          s;
    logic [7:0]    op;
    logic          ill;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  m6502_sequencer #(.TIMING_WIDTH(TW), .ENABLE_WIDTH(EW)) dut (
    .clock   (clock),
    .reset   (reset),
    .ready   (ready),
    .data_in (data_in),
    .timing  (timing),
    .opcode  (opcode),
    .sync    (sync),
    .enables (enables),
    .illegal (illegal)
  );

  always #5 clock = ~clock;

  task automatic step(input logic r, input logic rd, input logic [7:0] d,
                      input logic [TW-1:0] t, input logic [EW-1:0] en,
                      input logic s, input logic [7:0] op, input logic ill);
    exp_t e;
    @(posedge clock);
    #1;
    reset   = r;
    ready   = rd;
    data_in = d;
    cyc++;
    e.id = cyc; e.t = t; e.en = en; e.s = s; e.op = op; e.ill = ill;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("timing",  e.id, 64'(timing),  64'(e.t));
        chk("enables", e.id, enables,      e.en);
        chk("sync",    e.id, 64'(sync),    64'(e.s));
        chk("opcode",  e.id, 64'(opcode),  64'(e.op));
        chk("illegal", e.id, 64'(illegal), 64'(e.ill));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d steps issued", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held for three cycles, then NOP.
    repeat (3) step(1, 1, 8'hEA, 8'h01, TR, 1, 8'hEA, 0);
    step(0, 1, 8'hEA, 8'h01, IRL | PCI, 1, 8'hEA, 0);
    step(0, 1, 8'h00, 8'h02, TR,        0, 8'hEA, 0);
    // Immediates.
    step(0, 1, 8'hA9, 8'h01, IRL | PCI,       1, 8'hEA, 0);
    step(0, 1, 8'h42, 8'h02, PCI | RA | TR,   0, 8'hA9, 0);
    step(0, 1, 8'hA2, 8'h01, IRL | PCI,       1, 8'hA9, 0);
    step(0, 1, 8'h11, 8'h02, PCI | RX | TR,   0, 8'hA2, 0);
    step(0, 1, 8'hA0, 8'h01, IRL | PCI,       1, 8'hA2, 0);
    step(0, 1, 8'h22, 8'h02, PCI | RY | TR,   0, 8'hA0, 0);
    // JMP abs.
    step(0, 1, 8'h4C, 8'h01, IRL | PCI,       1, 8'hA0, 0);
    step(0, 1, 8'h00, 8'h02, PCI | ADL,       0, 8'h4C, 0);
    step(0, 1, 8'h80, 8'h04, ADH | PCL | TR,  0, 8'h4C, 0);
    // LDA abs.
    step(0, 1, 8'hAD, 8'h01, IRL | PCI,       1, 8'h4C, 0);
    step(0, 1, 8'h34, 8'h02, PCI | ADL,       0, 8'hAD, 0);
    step(0, 1, 8'h12, 8'h04, PCI | ADH,       0, 8'hAD, 0);
    step(0, 1, 8'h55, 8'h08, ASA | RA | TR,   0, 8'hAD, 0);
    // STA abs with a stalled T2 and a write T3 under ready low.
    step(0, 1, 8'h8D, 8'h01, IRL | PCI,       1, 8'hAD, 0);
    step(0, 1, 8'h10, 8'h02, PCI | ADL,       0, 8'h8D, 0);
    step(0, 0, 8'h20, 8'h04, NONE,            0, 8'h8D, 0);
    step(0, 1, 8'h20, 8'h04, PCI | ADH,       0, 8'h8D, 0);
    step(0, 0, 8'h99, 8'h08, ASA | WE | TR,   0, 8'h8D, 0);
    // Stalled T0: sync stays high, opcode not loaded.
    step(0, 0, 8'hEA, 8'h01, NONE,            1, 8'h8D, 0);
    step(0, 1, 8'hEA, 8'h01, IRL | PCI,       1, 8'h8D, 0);
    step(0, 1, 8'h00, 8'h02, TR,              0, 8'hEA, 0);
    // Illegal opcode 02.
    step(0, 1, 8'h02, 8'h01, IRL | PCI,       1, 8'hEA, 0);
`ifdef M6502_ILLEGAL_TRAP_EN
    step(0, 1, 8'hA9, 8'h02, NONE,            0, 8'h02, 0);
    repeat (10) step(0, 1, 8'hA9, 8'h02, NONE, 0, 8'h02, 1);
    step(1, 1, 8'hEA, 8'h02, TR,              0, 8'h02, 1);
`else
    step(0, 1, 8'hEA, 8'h02, TR,              0, 8'h02, 0);
    step(1, 1, 8'hEA, 8'h01, TR,              1, 8'h02, 0);
`endif
    // Reset in T2 of LDA abs aborts the instruction.
    step(0, 1, 8'hAD, 8'h01, IRL | PCI,       1, 8'hEA, 0);
    step(0, 1, 8'h00, 8'h02, PCI | ADL,       0, 8'hAD, 0);
    step(1, 1, 8'h12, 8'h04, TR,              0, 8'hAD, 0);
    step(0, 1, 8'hEA, 8'h01, IRL | PCI,       1, 8'hEA, 0);
    step(0, 1, 8'hEA, 8'h02, TR,              0, 8'hEA, 0);

    @(posedge clock);
    @(negedge clock);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d unchecked entries expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
